// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer handshake and status bundle for sync_fifo
interface sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, wr_ptr, rd_ptr
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, wr_ptr, rd_ptr
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and registered read data
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              rd_accept;

    // rst_n is active-high despite its name
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            end
        end
    end

    // storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (wr_accept && !rst_n) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.wr_ptr  = wr_ptr_q;
    assign bus.rd_ptr  = rd_ptr_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   ew    = 0;
    int   er    = 0;

    sync_fifo_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    sync_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ptrs(input string tag);
        check({tag, "_wptr"}, 32'(bus.wr_ptr), 32'(ew % 16));
        check({tag, "_rptr"}, 32'(bus.rd_ptr), 32'(er % 16));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wptr"},  32'(bus.wr_ptr),  0);
        check({tag, "_rptr"},  32'(bus.rd_ptr),  0);
        check({tag, "_empty"}, 32'(bus.empty),   1);
        check({tag, "_full"},  32'(bus.full),    0);
        check({tag, "_rdata"}, 32'(bus.rd_data), 0);
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        tick();
        check_reset_vals("rst");
        @(negedge clk);
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick();
            ew++;
            check("fill_wptr",  32'(bus.wr_ptr), 32'(ew % 16));
            check("fill_full",  32'(bus.full),   32'(i == 8));
            check("fill_empty", 32'(bus.empty),  0);
        end
        bus.wr_data = 8'd9;
        tick();
        check("fill9_wptr", 32'(bus.wr_ptr), 8);
        check("fill9_full", 32'(bus.full),   1);
        bus.wr_en = 1'b0;

        bus.rd_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i <= 8) er++;
            check("drain_rdata", 32'(bus.rd_data), 32'((i <= 8) ? i : 8));
            check("drain_rptr",  32'(bus.rd_ptr),  32'(er % 16));
            check("drain_empty", 32'(bus.empty),   32'(i >= 8));
            check("drain_full",  32'(bus.full),    0);
        end
        bus.rd_en = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = (i > 5);
            bus.wr_data = 8'(i);
            tick();
            ew++;
            if (i > 5) begin
                er++;
                check("stream_rdata", 32'(bus.rd_data), 32'(i - 5));
            end
            check_ptrs("stream");
            check("stream_full",  32'(bus.full),  0);
            check("stream_empty", 32'(bus.empty), 0);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 6; i <= 10; i++) begin
            tick();
            er++;
            check("stream_tail", 32'(bus.rd_data), 32'(i));
        end
        check("stream_end_empty", 32'(bus.empty), 1);
        bus.rd_en = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'b0;
            bus.wr_data = 8'(8'h10 + i);
            tick();
            ew++;
            check("wrap_w_empty", 32'(bus.empty), 0);
            check("wrap_w_full",  32'(bus.full),  0);
            check_ptrs("wrap_w");
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b1;
            tick();
            er++;
            check("wrap_rdata",   32'(bus.rd_data), 32'(8'h10 + i));
            check("wrap_r_empty", 32'(bus.empty),   1);
            check_ptrs("wrap_r");
        end
        bus.rd_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'hA0 + i);
            tick();
            ew++;
        end
        check("bf_full", 32'(bus.full), 1);
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hFF;
        tick();
        er++;
        check("bf_rdata", 32'(bus.rd_data), 32'h0A0);
        check("bf_full_after", 32'(bus.full), 0);
        check_ptrs("bf");
        bus.wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            er++;
            check("bf_drain", 32'(bus.rd_data), 32'(8'hA0 + i));
        end
        check("bf_drain_empty", 32'(bus.empty), 1);

        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        ew++;
        check("be_rdata_hold", 32'(bus.rd_data), 32'h0A7);
        check("be_empty", 32'(bus.empty), 0);
        check_ptrs("be");
        bus.wr_en = 1'b0;
        tick();
        er++;
        check("be_rdata", 32'(bus.rd_data), 32'h055);
        bus.rd_en = 1'b0;

        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h33;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n       = 1'b0;
        ew          = 0;
        er          = 0;
        bus.wr_data = 8'h77;
        tick();
        ew++;
        check_ptrs("post_rst");
        check("post_rst_empty", 32'(bus.empty), 0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        er++;
        check("post_rst_rdata", 32'(bus.rd_data), 32'h077);
        check("post_rst_empty2", 32'(bus.empty), 1);
        bus.rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO buffering 8-bit data words between a producer and a consumer in the same clock domain. Storage is a parameterised register array with binary read/write pointers that carry one extra wrap bit. Full and empty flags derive directly from those pointers. The pointers are exported for debug and observation.

## Interface
- DATA_W, default 8: data word width.
- ADDR_W, default 3: address width; depth = 2**ADDR_W = 8 entries.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-high. Despite the `_n` suffix, 1 = reset asserted.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  data to write.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- wr_ptr  output  ADDR_W+1 (4)  write pointer; MSB is the wrap bit.
- rd_ptr  output  ADDR_W+1 (4)  read pointer; MSB is the wrap bit.

## Operation
- **Reset (rst_n=1, asynchronous):**
  - wr_ptr=0, rd_ptr=0, rd_data=0, so empty=1 and full=0.
  - Memory contents are not cleared.
  - Reset held high holds all of these values regardless of clk or enables.
- **Write accepted** when wr_en=1 and full=0, both sampled at the clock edge:
  - mem[wr_ptr[ADDR_W-1:0]] <= wr_data.
  - wr_ptr <= wr_ptr+1, modulo 2**(ADDR_W+1).
- **Read accepted** when rd_en=1 and empty=0:
  - rd_data <= mem[rd_ptr[ADDR_W-1:0]].
  - rd_ptr <= rd_ptr+1, modulo 2**(ADDR_W+1).
- **Flags** are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
- **Write when full:** ignored; no pointer or memory change; no error flag.
- **Read when empty:** ignored; rd_data holds its previous value; rd_ptr unchanged.
- **Simultaneous wr_en and rd_en:**
  - Neither full nor empty: both operations occur in the same cycle; occupancy is unchanged.
  - Full: only the read occurs; the write is dropped.
  - Empty: only the write occurs; the read is dropped (no fall-through).
- rd_data changes only on an accepted read or on reset; otherwise it holds.
- The pointer wrap bit toggles every DEPTH accepted operations. Wrap-around from 4'b1111 to 4'b0000 is seamless.

## Timing
- Write latency:
  - Data written at edge N is readable by a read request sampled at edge N+1.
  - empty deasserts just after edge N, combinationally from wr_ptr.
- Read latency: one cycle. With rd_en=1 sampled at edge N, rd_data is valid after edge N and stays stable until the next accepted read.
- full asserts immediately after the edge that accepts the 8th unread write.
- full clears after the edge of the first accepted read.
- Reset assertion mid-operation takes effect immediately, without waiting for clk. Any data in flight is discarded.
- First edge after reset release operates normally.

## Test plan
- **Reset:** assert rst_n=1 at t=0, then release.
  - During reset: wr_ptr=0, rd_ptr=0, empty=1, full=0, rd_data=0.
  - After an async assert in mid-run, the same values appear before the next clk edge.
- **Fill:** wr_en=1, rd_en=0, write data 1..8 on consecutive cycles.
  - After the 8th edge: wr_ptr=4'b1000, full=1, empty=0.
  - A 9th write of value 9 is ignored; wr_ptr stays 8.
- **Drain:** after Fill, rd_en=1, wr_en=0 for 9 cycles.
  - rd_data = 1,2,...,8 on successive edges.
  - empty=1 after the 8th read; rd_ptr=4'b1000.
  - The 9th read leaves rd_data=8 and rd_ptr unchanged.
- **Concurrent streaming:**
  - Write data 1..5 with wr_en only.
  - Then assert rd_en alongside wr_en while writing 6..10.
  - Reads return 1,2,3,4,5 in order.
  - Occupancy stays 5; full=0, empty=0 throughout.
- **Wrap-around:** run 20 write/read pairs (data 0x10..0x23) through the FIFO.
  - Pointers pass 4'b1111 to 4'b0000.
  - Data order is preserved; flags are correct at every cycle.
- **Full/empty boundary with both enables:**
  - When full with wr_en=rd_en=1: the oldest word is read, the write is dropped, and full=0 afterwards.
  - When empty with both enables: the write is accepted, rd_data is unchanged, and empty=0 afterwards.
